// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ISSUE   = 3'd2,
        WAIT_PC = 3'd3,
        SETTLE  = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_seq_rise_det.sv
// rise_det: registered rising-edge detector; the history register resets to RST_VAL
// so a level already high when reset releases is not mistaken for a new rise.
module rise_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic hist_r;

    // one-cycle-delayed copy of the input
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= RST_VAL;
        end else begin
            hist_r <= d;
        end
    end

    assign rise = d & ~hist_r;

endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: fetches instruction words at the current PC and strobes them to the control unit.
// Build option IFETCH_ALIGN_CHECK_EN: misaligned PCs fault instead of being rounded down.
module ifetch_seq
    import ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned ENB_HOLD = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HALT,
    input  logic [31:0] PC_ADDR,
    input  logic        PC_CLK,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] MEM_INST,
    output logic        INST_ENB,
    output logic [1:0]  FETCH_ERR,
    output logic        BUSY,
    output logic [31:0] INST_CNT
);

    localparam logic [31:0] TMO_LIM   = 32'(TIMEOUT);
    localparam logic [3:0]  HOLD_LAST = 4'(ENB_HOLD - 32'd1);

    state_t      state_r, state_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] inst_r, inst_s;
    logic        enb_r, enb_s;
    logic [1:0]  err_r, err_s;
    logic        busy_r, busy_s;
    logic [31:0] cnt_r, cnt_s;
    logic        pend_r, pend_s;
    logic [31:0] tmo_r, tmo_s;
    logic [3:0]  hold_r, hold_s;
    logic        pc_rise_s;
    logic        pc_bad_s;
    logic [31:0] pc_lat_s;

    rise_det #(.RST_VAL(1'b1)) u_pc_rise (
        .clk  (CLK),
        .rst  (RST),
        .d    (PC_CLK),
        .rise (pc_rise_s)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    assign pc_bad_s = (PC_ADDR[1:0] != 2'b00);
    assign pc_lat_s = PC_ADDR;
`else
    assign pc_bad_s = 1'b0;
    assign pc_lat_s = word_align(PC_ADDR);
`endif

    // next-state and next-output logic
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        addr_s  = addr_r;
        inst_s  = inst_r;
        enb_s   = enb_r;
        err_s   = err_r;
        cnt_s   = cnt_r;
        pend_s  = pend_r;
        tmo_s   = tmo_r;
        hold_s  = hold_r;

        case (state_r)
            IDLE, SETTLE: begin
                if (HALT) begin
                    state_s = IDLE;
                end else begin
                    addr_s = pc_lat_s;
                    if (pc_bad_s) begin
                        state_s = FAULT;
                        err_s   = ERR_MISALIGN;
                    end else begin
                        state_s = REQ;
                        req_s   = 1'b1;
                        tmo_s   = 32'd0;
                    end
                end
            end
            REQ: begin
                if (IMEM_ACK) begin
                    inst_s  = IMEM_RDATA;
                    req_s   = 1'b0;
                    enb_s   = 1'b1;
                    cnt_s   = cnt_r + 32'd1;
                    hold_s  = 4'd0;
                    state_s = ISSUE;
                end else begin
                    tmo_s = tmo_r + 32'd1;
                    if ((TMO_LIM != 32'd0) && (tmo_s == TMO_LIM)) begin
                        state_s = FAULT;
                        req_s   = 1'b0;
                        err_s   = ERR_TIMEOUT;
                    end else begin
                        state_s = REQ;
                    end
                end
            end
            ISSUE: begin
                // a completion arriving while the strobe is still high is remembered
                if (pc_rise_s) begin
                    pend_s = 1'b1;
                end else begin
                    pend_s = pend_r;
                end
                if (hold_r == HOLD_LAST) begin
                    enb_s   = 1'b0;
                    state_s = WAIT_PC;
                end else begin
                    hold_s = hold_r + 4'd1;
                end
            end
            WAIT_PC: begin
                if (pc_rise_s || pend_r) begin
                    pend_s  = 1'b0;
                    state_s = SETTLE;
                end else begin
                    state_s = WAIT_PC;
                end
            end
            FAULT: begin
                state_s = FAULT;
                req_s   = 1'b0;
                enb_s   = 1'b0;
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
                enb_s   = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE) && (state_s != FAULT);
    end

    // state and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            addr_r  <= 32'd0;
            inst_r  <= NOP_INST;
            enb_r   <= 1'b0;
            err_r   <= ERR_NONE;
            busy_r  <= 1'b0;
            cnt_r   <= 32'd0;
            pend_r  <= 1'b0;
            tmo_r   <= 32'd0;
            hold_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            inst_r  <= inst_s;
            enb_r   <= enb_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
            tmo_r   <= tmo_s;
            hold_r  <= hold_s;
        end
    end

    assign IMEM_REQ  = req_r;
    assign IMEM_ADDR = addr_r;
    assign MEM_INST  = inst_r;
    assign INST_ENB  = enb_r;
    assign FETCH_ERR = err_r;
    assign BUSY      = busy_r;
    assign INST_CNT  = cnt_r;

endmodule

// File: doc/ifetch_seq.md
# ifetch_seq

Instruction-fetch sequencer feeding the control unit. It reads RV32I instruction words from instruction memory over a request/acknowledge handshake at the current PC. Each word is presented on `MEM_INST` with a rising `INST_ENB` strobe. The next fetch starts only after the control unit signals completion with a rising `PC_CLK` and the PC has settled.

## Interface
- `TIMEOUT`, default 255: maximum cycles `REQ` may wait for `IMEM_ACK`. A value of 0 disables the timeout.
- `ENB_HOLD`, default 1: number of cycles `INST_ENB` stays high per instruction. Range 1–15.
- `CLK` in 1: clock; all logic updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `HALT` in 1: blocks the start of new fetches.
- `PC_ADDR` in 32: current PC from the PC register.
- `PC_CLK` in 1: completion level from the control unit.
- `IMEM_ACK` in 1: memory data valid.
- `IMEM_RDATA` in 32: instruction word from memory.
- `IMEM_REQ` out 1: fetch request.
- `IMEM_ADDR` out 32: fetch address, registered.
- `MEM_INST` out 32: instruction presented to the control unit.
- `INST_ENB` out 1: instruction strobe; the control unit acts on its rising edge.
- `FETCH_ERR` out 2: fault cause. 00 = none, 01 = timeout, 10 = misaligned.
- `BUSY` out 1: high in every state except `IDLE` and `FAULT`.
- `INST_CNT` out 32: count of issued instructions; wraps modulo 2^32.

## Operation
- States: `IDLE`, `REQ`, `ISSUE`, `WAIT_PC`, `SETTLE`, `FAULT`.
- Reset values:
  - state `IDLE`
  - `IMEM_REQ` = 0, `IMEM_ADDR` = 0
  - `MEM_INST` = 32'h0000_0013 (NOP)
  - `INST_ENB` = 0, `FETCH_ERR` = 00, `BUSY` = 0, `INST_CNT` = 0
  - PC_CLK history register = 1
  - pending flag = 0, timeout counter = 0
- `IDLE`: if `HALT` = 0, latch `PC_ADDR` into `IMEM_ADDR` and go to `REQ`.
- `REQ`: `IMEM_REQ` = 1 and `IMEM_ADDR` held stable.
  - On an edge with `IMEM_ACK` = 1: latch `IMEM_RDATA` into `MEM_INST`, clear `IMEM_REQ`, go to `ISSUE`.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT` (nonzero), go to `FAULT` with cause 01.
- `ISSUE`: `INST_ENB` = 1 for `ENB_HOLD` cycles, then `INST_ENB` = 0 and go to `WAIT_PC`. `INST_CNT` increments once, on entry.
- `WAIT_PC`: leave when a `PC_CLK` rise is detected now or the pending flag is set; clear the flag and go to `SETTLE`.
- `SETTLE`: one cycle so the PC register can update.
  - If `HALT` = 1, go to `IDLE`.
  - Otherwise latch `PC_ADDR` into `IMEM_ADDR` and go to `REQ`.
- `FAULT`: terminal until `RST`. `IMEM_REQ` = 0, `INST_ENB` = 0, `FETCH_ERR` holds its cause.
- `PC_CLK` rise detection runs in every state: `PC_CLK` & ~history. A rise during `ISSUE` sets the pending flag. Rises outside `ISSUE`/`WAIT_PC` are ignored.
- `MEM_INST` is stable from the `ACK` edge until the next `ACK` edge.

## Timing
- Zero-wait memory: `REQ` lasts 1 cycle (`ACK` sampled high on the first edge).
- `INST_ENB` rises exactly 1 cycle after the `ACK` edge.
- Minimum loop with zero-wait memory and an immediate `PC_CLK` rise: `REQ`, `ISSUE`, `WAIT_PC`, `SETTLE` = 4 cycles per instruction when `ENB_HOLD` = 1.
- `INST_ENB` is always low for at least 1 cycle between instructions.
- `RST` wins over a simultaneous `ACK`, `PC_CLK` rise or timeout. Reset mid-fetch drops the outstanding request, and any late `ACK` is ignored in `IDLE`.
- `HALT` does not abort `REQ`/`ISSUE`/`WAIT_PC`. It takes effect only in `SETTLE` and `IDLE`.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined: when latching the PC in `IDLE`/`SETTLE`, `PC_ADDR[1:0]` ≠ 00 forces `FAULT` with cause 10, and `REQ` is never asserted.
- `IFETCH_ALIGN_CHECK_EN` undefined: `IMEM_ADDR[1:0]` is forced to 00 and the misaligned cause never occurs.

## Structure
- Package `ifetch_pkg` holds:
  - the state enum
  - `NOP_INST` = 32'h0000_0013
  - error codes `ERR_NONE`, `ERR_TIMEOUT`, `ERR_MISALIGN`
- Sub-module `rise_det`: registered rising-edge detector with a reset value parameter. It is used for `PC_CLK`.

## Test plan
- Reset, `HALT` = 0, `PC_ADDR` = 0x0, `ACK` tied high, `PC_CLK` pulsed 1 cycle after each `INST_ENB` fall → instruction words fetched at addresses 0x0, 0x4, 0x8 (PC model steps by 4), with the 4-cycle loop and `INST_CNT` = 3.
- `ACK` delayed 5 cycles → `IMEM_ADDR` stable during the wait, `MEM_INST` = `RDATA` (e.g. 0x00500093), `INST_ENB` rises on the next cycle.
- `TIMEOUT` = 8, `ACK` never asserted → `FETCH_ERR` = 01 on the 8th waiting edge, `BUSY` = 0, no further `REQ` until `RST`.
- `PC_CLK` rises while `INST_ENB` is high (pending flag) → exactly one advance to `SETTLE` with no lost or duplicate fetch.
- `RST` asserted in `REQ` together with `ACK` → all outputs return to their reset values the next cycle and `MEM_INST` = 0x00000013.
- With `IFETCH_ALIGN_CHECK_EN`, `PC_ADDR` = 0x6 → `FETCH_ERR` = 10 and `IMEM_REQ` is never asserted. Without the macro, `IMEM_ADDR` = 0x4.
